// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and decoded-key signal bundle
interface keypad_scanner_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 3,
  parameter int CODE_W = 4
);
  logic [ROWS-1:0]   key_row;
  logic [COLS-1:0]   key_col;
  logic [CODE_W-1:0] key_code;
  logic              key_held;
  logic              key_valid;
  logic              key_release;

  // Scanner side: senses rows, drives column strobes and the decoded key.
  modport master (
    input  key_row,
    output key_col, key_code, key_held, key_valid, key_release
  );

  // Keypad/consumer side.
  modport slave (
    output key_row,
    input  key_col, key_code, key_held, key_valid, key_release
  );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - matrix keypad column scanner with frame debouncer
module keypad_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 3,
  parameter int DIV      = 12500,
  parameter int DEBOUNCE = 4,
  parameter int CODE_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  bus
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

  // Column states; only COL_0..COL_{COLS-1} are ever visited.
  typedef enum logic [2:0] {
    COL_0, COL_1, COL_2, COL_3, COL_4, COL_5, COL_6, COL_7
  } col_state_t;

  localparam col_state_t COL_LAST = col_state_t'(3'(COLS - 1));

  logic [TW-1:0]     tick_cnt;
  logic              tick;
  col_state_t        col_state;
  logic [COLS-1:0]   key_col_q;
  logic [CODE_W-1:0] row_code;
  logic [CODE_W-1:0] frame_code;
  logic [CODE_W-1:0] acc;
  logic [CODE_W-1:0] cand;
  logic [3:0]        stable_cnt;
  logic              frame_end;
  logic [CODE_W-1:0] key_code_q;
  logic              key_held_q;
  logic              key_valid_q;
  logic              key_release_q;

  assign tick      = (tick_cnt == TW'(DIV - 1));
  assign frame_end = tick && (col_state == COL_LAST);

  assign bus.key_col     = key_col_q;
  assign bus.key_code    = key_code_q;
  assign bus.key_held    = key_held_q;
  assign bus.key_valid   = key_valid_q;
  assign bus.key_release = key_release_q;

  // Free-running scan divider; tick marks the last cycle of each column dwell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Column FSM: advance one column per tick, wrapping after the last column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_state <= COL_0;
      key_col_q <= COLS'(1);
    end else if (tick) begin
      if (col_state == COL_LAST) begin
        col_state <= COL_0;
        key_col_q <= COLS'(1);
      end else begin
        col_state <= col_state_t'(col_state + 3'd1);
        key_col_q <= key_col_q << 1;
      end
    end
  end

  // Code of the lowest pressed row in the current column; the accumulator
  // keeps the first key found in scan order for the whole frame.
  always_comb begin
    row_code = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (bus.key_row[r]) begin
        row_code = CODE_W'(r * COLS + int'(col_state) + 1);
      end
    end
    frame_code = (acc != '0) ? acc : row_code;
  end

  // Frame accumulator and debouncer: count consecutive identical frame codes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      cand       <= '0;
      stable_cnt <= 4'(DEBOUNCE);
    end else if (frame_end) begin
      acc <= '0;
      if (frame_code == cand) begin
        if (stable_cnt != 4'(DEBOUNCE)) begin
          stable_cnt <= stable_cnt + 4'd1;
        end
      end else begin
        cand       <= frame_code;
        stable_cnt <= 4'd1;
      end
    end else if (tick) begin
      acc <= frame_code;
    end
  end

  // Commit a stable candidate and emit the matching press/release pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code_q    <= '0;
      key_held_q    <= 1'b0;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      if (stable_cnt == 4'(DEBOUNCE) && cand != key_code_q) begin
        key_code_q    <= cand;
        key_held_q    <= (cand != '0);
        key_valid_q   <= (cand != '0);
        key_release_q <= (key_code_q != '0);
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - table, directed and random checks of keypad_scanner
module tb_keypad_scanner;

  localparam int DIV   = 4;
  localparam int DEB   = 3;
  localparam int FRAME = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if #(.ROWS(4), .COLS(3), .CODE_W(4)) bus ();
  keypad_scanner_if #(.ROWS(2), .COLS(2), .CODE_W(3)) bus2 ();

  keypad_scanner #(.ROWS(4), .COLS(3), .DIV(DIV), .DEBOUNCE(DEB), .CODE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  keypad_scanner #(.ROWS(2), .COLS(2), .DIV(DIV), .DEBOUNCE(DEB), .CODE_W(3)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Pressed-key masks: bit (row*COLS + col) set means that switch is closed.
  logic [11:0] pressed  = '0;
  logic [3:0]  pressed2 = '0;

  // Keypad matrix: a row reads high when a closed switch sits in the strobed column.
  always_comb begin
    for (int r = 0; r < 4; r++) bus.key_row[r] = |(pressed[r*3 +: 3] & bus.key_col);
    for (int r = 0; r < 2; r++) bus2.key_row[r] = |(pressed2[r*2 +: 2] & bus2.key_col);
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [11:0] kbit(input int code);
    logic [11:0] one;
    one = 12'd1;
    return one << (code - 1);
  endfunction

  // Apply one frame of keys; the commit (if any) lands on the first edge.
  task automatic run_frame(input logic [11:0] keys, input int ecode, input bit ev, input bit er);
    logic [2:0] ecol;
    pressed = keys;
    for (int i = 1; i <= FRAME; i++) begin
      step();
      ecol = 3'b001 << ((i / DIV) % 3);
      check("key_col", bus.key_col, ecol);
      check("key_code", bus.key_code, ecode);
      check("key_held", bus.key_held, ecode != 0);
      check("key_valid", bus.key_valid, (i == 1) ? ev : 1'b0);
      check("key_release", bus.key_release, (i == 1) ? er : 1'b0);
    end
  endtask

  // Reference model: the frame code is the first closed key in column-major
  // order; a code is committed once the last DEB frame codes all agree.
  int hist[$];
  int mcode;
  bit pend;
  int pcode;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DEB; i++) hist.push_back(0);
    mcode = 0;
    pend  = 1'b0;
  endtask

  function automatic int fcode(input logic [11:0] keys);
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 4; r++)
        if (keys[r*3 + c]) return r*3 + c + 1;
    return 0;
  endfunction

  task automatic model_frame(input logic [11:0] keys);
    bit ev, er, same;
    ev = pend && pcode != 0;
    er = pend && mcode != 0;
    if (pend) mcode = pcode;
    pend = 1'b0;
    run_frame(keys, mcode, ev, er);
    hist.push_back(fcode(keys));
    void'(hist.pop_front());
    same = 1'b1;
    foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
    if (same && hist[0] != mcode) begin
      pend  = 1'b1;
      pcode = hist[0];
    end
  endtask

  typedef struct {
    logic [11:0] keys;
    int          n;
    int          code;
    bit          v;
    bit          r;
  } vec_t;

  vec_t vecs[$];
  logic [11:0] prev;
  int sel;

  initial begin
    // keys, frames, expected code / valid / release on the first edge of the run
    vecs.push_back('{kbit(5),            3,  0, 1'b0, 1'b0});
    vecs.push_back('{kbit(5),           10,  5, 1'b1, 1'b0});
    vecs.push_back('{12'd0,              3,  5, 1'b0, 1'b0});
    vecs.push_back('{12'd0,              1,  0, 1'b0, 1'b1});
    vecs.push_back('{kbit(12),           2,  0, 1'b0, 1'b0});
    vecs.push_back('{12'd0,              1,  0, 1'b0, 1'b0});
    vecs.push_back('{kbit(12),           3,  0, 1'b0, 1'b0});
    vecs.push_back('{kbit(12),           1, 12, 1'b1, 1'b0});
    vecs.push_back('{kbit(1),            3, 12, 1'b0, 1'b0});
    vecs.push_back('{kbit(1),            1,  1, 1'b1, 1'b1});
    vecs.push_back('{kbit(9),            3,  1, 1'b0, 1'b0});
    vecs.push_back('{kbit(9),            1,  9, 1'b1, 1'b1});
    vecs.push_back('{kbit(3) | kbit(4),  3,  9, 1'b0, 1'b0});
    vecs.push_back('{kbit(3) | kbit(4),  1,  4, 1'b1, 1'b1});
    vecs.push_back('{12'd0,              3,  4, 1'b0, 1'b0});
    vecs.push_back('{12'd0,              1,  0, 1'b0, 1'b1});

    repeat (2) @(negedge clk);
    check("rst_key_col", bus.key_col, 3'b001);
    check("rst_key_code", bus.key_code, 0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      for (int j = 0; j < vecs[k].n; j++) begin
        if (j == 0) run_frame(vecs[k].keys, vecs[k].code, vecs[k].v, vecs[k].r);
        else        run_frame(vecs[k].keys, vecs[k].code, 1'b0, 1'b0);
      end
    end

    // Reset mid-frame while a committed key is still held.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int f = 0; f < 4; f++) model_frame(kbit(5));
    repeat (5) step();
    rst = 1'b1;
    #1;
    check("async_rst_key_col", bus.key_col, 3'b001);
    check("async_rst_key_code", bus.key_code, 0);
    check("async_rst_key_held", bus.key_held, 0);
    check("async_rst_key_valid", bus.key_valid, 0);
    check("async_rst_key_release", bus.key_release, 0);
    @(negedge clk);
    step();
    check("hold_rst_key_col", bus.key_col, 3'b001);
    check("hold_rst_key_code", bus.key_code, 0);
    rst = 1'b0;
    model_reset();

    // Random key sequences against the reference model; key 5 is still
    // pressed, so the first frames also cover the post-reset restart.
    prev = kbit(5);
    for (int f = 0; f < 40; f++) begin
      sel = $urandom_range(0, 9);
      if (sel == 6)      prev = 12'd0;
      else if (sel >= 7 && sel <= 8) prev = kbit($urandom_range(1, 12));
      else if (sel == 9) prev = kbit($urandom_range(1, 12)) | kbit($urandom_range(1, 12));
      model_frame(prev);
    end

    // 2x2 keypad: row 1 col 1 is code 4; then codes 2 and 3 together give 3.
    rst = 1'b1;
    pressed  = '0;
    pressed2 = 4'b1000;
    @(negedge clk);
    rst = 1'b0;
    repeat (3 * 8) step();
    check("k22_before_commit", bus2.key_code, 0);
    step();
    check("k22_code", bus2.key_code, 4);
    check("k22_valid", bus2.key_valid, 1);
    check("k22_held", bus2.key_held, 1);
    pressed2 = 4'b0110;
    repeat (23) step();
    check("k22_multi_before", bus2.key_code, 4);
    step();
    check("k22_multi_code", bus2.key_code, 3);
    check("k22_multi_valid", bus2.key_valid, 1);
    check("k22_multi_release", bus2.key_release, 1);
    step();
    check("k22_valid_single", bus2.key_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Parametrised matrix-keypad scanner that replaces the fixed 4x3 scan/decode used by the game top. It drives one-hot column strobes from a divided scan tick and samples the row inputs. It debounces the result over whole scan frames and emits clean press/release events plus a held level for game and menu logic. Scanning never stalls on a pressed key, so multi-key and key-change cases are resolved deterministically.

Parameters:
ROWS, 4, number of row inputs (2..8)
COLS, 3, number of column strobes (2..8)
DIV, 12500, clk cycles per scan tick (>=2)
DEBOUNCE, 4, consecutive identical frames required to commit a new code (1..15)
CODE_W, 4, key code width; must satisfy 2^CODE_W > ROWS*COLS

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
key_row  in  ROWS  row sense lines, active-high, bit r = row r
key_col  out  COLS  one-hot column strobe, active-high, bit c = column c
key_code  out  CODE_W  debounced code; 0 = no key, else row*COLS+col+1 (4x3: 1..9 digits, 10='*', 11='0', 12='#')
key_held  out  1  level, high while key_code != 0
key_valid  out  1  one-cycle pulse when a new nonzero code is committed
key_release  out  1  one-cycle pulse when a nonzero code is replaced or cleared

Behaviour:
- Reset (async, any time incl. mid-frame): tick counter=0, column index=0, key_col=1 (column 0 driven), frame accumulator=0, candidate=0, stable count=DEBOUNCE (saturated), key_code=0, key_held=0, key_valid=0, key_release=0.
- Tick: counter runs 0..DIV-1 and wraps; tick asserted for the one cycle where counter==DIV-1.
- Column FSM: states COL_0..COL_{COLS-1}, one-hot on key_col. On tick: sample key_row for the current column, then advance; COL_{COLS-1} wraps to COL_0. Each column dwells exactly DIV cycles. One frame = COLS*DIV cycles.
- Frame accumulator: on each sample, if accumulator==0 and key_row!=0, store the code of the lowest set row bit in this column. The first pressed key in scan order (lowest column, then lowest row) wins. Other simultaneous keys are ignored.
- Frame end = the tick in COL_{COLS-1}, with that column's sample included. The frame code is passed to the debouncer and the accumulator clears in the same cycle.
- Debouncer, at frame end:
  - if frame code == candidate: stable count increments, saturating at DEBOUNCE.
  - else: candidate <= frame code, count <= 1.
- Commit: on the cycle after count reaches DEBOUNCE with candidate != key_code, key_code <= candidate. Events fire in that same cycle:
  - 0 -> A: key_valid=1.
  - A -> 0: key_release=1.
  - A -> B, both nonzero: key_release=1 and key_valid=1 together, with key_code=B.
- A held key produces exactly one key_valid. There is no auto-repeat.
- Latency: with a key stable from before frame k starts, commit occurs 1 clk after the frame-end tick of frame k+DEBOUNCE-1. A bounce that lasts fewer than DEBOUNCE frames never changes key_code.
- key_held is registered together with key_code (key_held == (key_code!=0) at all times).
- Row bits are sampled only on tick. Glitches between ticks are invisible.

Test Plan:
(Bench parameters for all cases: DIV=4, DEBOUNCE=3, ROWS=4, COLS=3, so frame = 12 clk.)
- Reset: pulse rst mid-frame while a key is pressed -> immediately key_col=3'b001, key_code=0, key_held=0, no pulses. Scanning restarts from column 0 after rst falls.
- Clean press: key_row=4'b0010 whenever key_col=3'b010, held from a frame start -> single key_valid after 3 full frames (36 clk + 1), key_code=5, key_held=1. No further key_valid over 10 more frames.
- Release: release the key from the previous case -> key_release pulse after 3 frames, key_code=0, key_held=0, key_valid stays 0.
- Bounce: press '#' (row 3, col 2) for 2 frames, off 1 frame, on 2 frames -> key_code stays 0, no pulses. Holding a further 3 frames -> key_code=12 with one key_valid.
- Change without release: hold '1' (code 1) until committed, then switch directly to '9' -> after 3 frames, one cycle with key_release=1 and key_valid=1 together, key_code=9.
- Multi-key priority: '3' (row 0, col 2) and '4' (row 1, col 0) pressed together -> key_code=4, since column 0 is scanned first. Reparametrise ROWS=2, COLS=2: pressing row 1, col 1 -> key_code=4.
